// File: rtl/noc_tx_pio_arbiter.sv
// Round-robin arbiter that shares one NoC data-out PIO register between N_REQ requesters.
// Packets are never interleaved, and every PIO write is followed by a programmable idle gap.
module noc_tx_pio_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned GAP_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic [1:0]            address,
    output logic                  chipselect,
    output logic                  write_n,
    output logic [31:0]           writedata,
    output logic [2:0]            grant_id,
    output logic                  locked
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {ARB, WRITE, GAP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [GAP_W-1:0]   gap_cnt;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [31:0]        win_data;
    logic [IDX_W:0]     cand_sum;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   rr_next;

    assign address  = 2'b00;
    assign grant_id = 3'(grant_idx);
    assign rr_next  = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    // Winner search: locked packets only look at their owner, otherwise rotate from rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        req_ready = '0;
        if (state == ARB && reset_n) begin
            if (locked) begin
                if (req_valid[grant_idx]) begin
                    win_found = 1'b1;
                    win_idx   = grant_idx;
                end
            end else begin
                for (int unsigned k = 0; k < N_REQ; k++) begin
                    cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
                    if (cand_sum >= (IDX_W+1)'(N_REQ))
                        cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
                    cand = cand_sum[IDX_W-1:0];
                    if (!win_found && req_valid[cand]) begin
                        win_found = 1'b1;
                        win_idx   = cand;
                    end
                end
            end
            if (win_found)
                req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        win_data = req_data[int'(win_idx)*32 +: 32];
    end

    // Arbitration FSM with registered PIO strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            locked     <= 1'b0;
            gap_cnt    <= '0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (win_found) begin
                        writedata  <= win_data;
                        grant_idx  <= win_idx;
                        locked     <= ~req_last[win_idx];
                        chipselect <= 1'b1;
                        write_n    <= 1'b0;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    chipselect <= 1'b0;
                    write_n    <= 1'b1;
                    // Pointer only moves at packet end so packets stay contiguous.
                    if (!locked)
                        rr_ptr <= rr_next;
                    if (GAP_CYCLES > 0) begin
                        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                        state   <= GAP;
                    end else begin
                        state   <= ARB;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0)
                        state <= ARB;
                    else
                        gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_tx_pio_arbiter.sv
// Randomized bench for noc_tx_pio_arbiter against a transaction-level model built from
// per-requester packet queues, an arbiter-free time and a rotation pointer.
module tb_noc_tx_pio_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned GAP = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [2:0]        grant_id;
    logic              locked;

    noc_tx_pio_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .GAP_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .grant_id(grant_id), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } word_t;

    word_t q [N][$];

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    // Model state
    int          cyc;
    int          free_at;
    int          rr;
    int          m_gid;
    bit          m_lock;
    bit          exp_wr;
    logic [31:0] exp_wd;
    int          n_writes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        rr      = 0;
        m_gid   = 0;
        m_lock  = 1'b0;
        exp_wr  = 1'b0;
        exp_wd  = '0;
        free_at = cyc;
    endtask

    task automatic refill(input int pct);
        for (int i = 0; i < N; i++) begin
            if (q[i].size() == 0 && $urandom_range(99) < pct) begin
                int len;
                len = $urandom_range(1, 3);
                for (int j = 0; j < len; j++) begin
                    word_t w;
                    w.d = $urandom;
                    w.l = (j == len - 1);
                    q[i].push_back(w);
                end
            end
        end
    endtask

    // One clock: drive after the edge, check and advance the model at the falling edge.
    task automatic step(input int drop_pct, input int refill_pct);
        int exp_w;
        logic [N-1:0] exp_ready;
        @(posedge clk);
        #1;
        refill(refill_pct);
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && $urandom_range(99) >= drop_pct) begin
                req_valid[i]          = 1'b1;
                req_data[32*i +: 32]  = q[i][0].d;
                req_last[i]           = q[i][0].l;
            end else begin
                req_valid[i]          = 1'b0;
                req_data[32*i +: 32]  = $urandom;
                req_last[i]           = 1'($urandom_range(1));
            end
        end
        @(negedge clk);
        check("chipselect", 32'(chipselect), 32'(exp_wr));
        check("write_n", 32'(write_n), 32'(!exp_wr));
        check("writedata", writedata, exp_wd);
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("locked", 32'(locked), 32'(m_lock));
        check("address", 32'(address), 32'd0);

        exp_w = -1;
        if (cyc >= free_at) begin
            if (m_lock) begin
                if (req_valid[m_gid]) exp_w = m_gid;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (rr + k) % N;
                    if (exp_w < 0 && req_valid[idx]) exp_w = idx;
                end
            end
        end
        exp_ready = (exp_w >= 0) ? N'(1) << exp_w : '0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));

        exp_wr = (exp_w >= 0);
        if (exp_w >= 0) begin
            exp_wd  = q[exp_w][0].d;
            m_gid   = exp_w;
            m_lock  = !q[exp_w][0].l;
            if (q[exp_w][0].l) rr = (exp_w + 1) % N;
            free_at = cyc + 2 + GAP;
            void'(q[exp_w].pop_front());
            n_writes++;
        end
        cyc++;
    endtask

    initial begin
        cyc      = 0;
        n_writes = 0;
        model_reset();

        // Reset with all requesters valid: nothing accepted, bus idle.
        reset_n   = 1'b0;
        req_valid = '1;
        req_data  = '1;
        req_last  = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_cs", 32'(chipselect), 32'd0);
        check("rst_wn", 32'(write_n), 32'd1);
        check("rst_wd", writedata, 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_lock", 32'(locked), 32'd0);
        req_valid = '0;
        reset_n   = 1'b1;

        // Saturated: every requester always has a packet, strict rotation.
        repeat (300) step(0, 100);
        // Sparse, with requesters dropping valid, including mid-packet stalls.
        repeat (600) step(30, 30);

        // Reset while the PIO write strobe is active.
        begin
            int guard;
            guard = 0;
            while (!exp_wr && guard < 100) begin
                step(0, 100);
                guard++;
            end
            check("t6_got_accept", 32'(exp_wr), 32'd1);
            @(posedge clk);
            #1;
            check("t6_cs_before", 32'(chipselect), 32'd1);
            reset_n = 1'b0;
            #1;
            check("t6_wn_reset", 32'(write_n), 32'd1);
            check("t6_cs_reset", 32'(chipselect), 32'd0);
            check("t6_lock_reset", 32'(locked), 32'd0);
            req_valid = '0;
            @(negedge clk);
            reset_n = 1'b1;
            model_reset();
        end

        repeat (400) step(20, 50);

        if (n_writes < 100) check("write_count_low", 32'(n_writes), 32'd100);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
